nes_controller_reader: RTL

Console-side reader for the NES controller serial interface. On request it drives a latch pulse and a controller clock, shifts back the eight active-low button bits from the pad, and presents them as an active-high parallel byte. It sits between the system logic and the pad pins, or the `nes_controller` model in simulation, and is the initiator for that responder.

---
 rtl/nes_pkg.sv | 32 +++
 rtl/nes_controller_reader.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/nes_pkg.sv
// Shared definitions for the NES controller reader: FSM states, button bit
// positions and default pad timing.
package nes_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LATCH    = 3'd1,
        SHIFT_HI = 3'd2,
        SHIFT_LO = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

    // 12 us latch and 6 us half-period at a 50 MHz system clock
    localparam int DEFAULT_LATCH_CYCLES = 600;
    localparam int DEFAULT_HALF_CYCLES  = 300;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/nes_controller_reader.sv
// Console-side NES pad reader: latch, eight clocked reads, active-high byte out.
// Optional two-poll agreement filter enabled by defining NES_READER_FILTER_EN.
module nes_controller_reader
    import nes_pkg::*;
#(
    parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES,
    parameter int HALF_CYCLES  = DEFAULT_HALF_CYCLES
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       serial_ni,
    output logic       latch_o,
    output logic       ctrl_clk_o,
    output logic       busy_o,
    output logic       valid_o,
    output logic [7:0] buttons_o
);

    localparam int CNT_W = cnt_width(LATCH_CYCLES, HALF_CYCLES);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_END   = CNT_W'(LATCH_CYCLES / 2);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       raw_q, raw_d;
    logic [7:0]       buttons_q, buttons_d;
    logic             latch_q, latch_d;
    logic             ctrl_clk_q, ctrl_clk_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
`ifdef NES_READER_FILTER_EN
    logic [7:0]       prev_q, prev_d;
`endif

    // Next-state, sampling and next-output logic; pin outputs are decoded
    // from the next state so they come straight off flops.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        raw_d     = raw_q;
        buttons_d = buttons_q;
`ifdef NES_READER_FILTER_EN
        prev_d    = prev_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LATCH;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = IDLE;
                end
            end
            LATCH: begin
                // The load pulse has already fallen, so bit A is settled here
                if (cnt_q == LATCH_LAST) begin
                    raw_d[BTN_A] = ~serial_ni;
                    idx_d        = 3'd6;
                    cnt_d        = CNT_ZERO;
                    state_d      = SHIFT_HI;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            SHIFT_HI: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = CNT_ZERO;
                    state_d = SHIFT_LO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            SHIFT_LO: begin
                if (cnt_q == HALF_LAST) begin
                    raw_d[idx_q] = ~serial_ni;
                    cnt_d        = CNT_ZERO;
                    if (idx_q == 3'd0) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q - 3'd1;
                        state_d = SHIFT_HI;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
`ifdef NES_READER_FILTER_EN
                if (raw_q == prev_q) begin
                    buttons_d = raw_q;
                end else begin
                    buttons_d = buttons_q;
                end
                prev_d = raw_q;
`else
                buttons_d = raw_q;
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        latch_d    = (state_d == LATCH);
        ctrl_clk_d = (state_d == SHIFT_HI) ||
                     ((state_d == LATCH) && (cnt_d >= CNT_ONE) && (cnt_d <= LOAD_END));
        busy_d     = (state_d != IDLE);
        valid_d    = (state_d == DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= CNT_ZERO;
            idx_q      <= 3'd0;
            raw_q      <= 8'h00;
            buttons_q  <= 8'h00;
            latch_q    <= 1'b0;
            ctrl_clk_q <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
`ifdef NES_READER_FILTER_EN
            prev_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            raw_q      <= raw_d;
            buttons_q  <= buttons_d;
            latch_q    <= latch_d;
            ctrl_clk_q <= ctrl_clk_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
`ifdef NES_READER_FILTER_EN
            prev_q     <= prev_d;
`endif
        end
    end

    assign latch_o    = latch_q;
    assign ctrl_clk_o = ctrl_clk_q;
    assign busy_o     = busy_q;
    assign valid_o    = valid_q;
    assign buttons_o  = buttons_q;

endmodule
